// File: rtl/warning_controller.sv
// warning_controller
//   Debounces N_WARN raw fault channels and splits the debounced warnings into
//   priority-1 (start-inhibiting) and priority-2 (advisory) classes. It drives a
//   start-interlock FSM whose lockout is cleared only by a key cycle, and a chime
//   cadence generator. The driver can acknowledge priority-2 warnings per channel.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   fault_raw    in   [N_WARN] raw fault conditions, 1 = fault present
//   key          in   key present
//   brk          in   brake pressed
//   park         in   gear in park
//   srv          in   service mode (bypasses lockout, silences priority-2 chime)
//   ack          in   driver acknowledge, sampled every cycle
//   warn         out  [N_WARN] debounced per-channel warnings (registered)
//   warn_pri1    out  any priority-1 warning active
//   warn_pri2    out  any priority-2 warning active
//   chime        out  audible chime drive
//   start_permit out  starter enable (state register decode)
module warning_controller #(
    parameter int                N_WARN    = 8,
    parameter int                DEB_CYC   = 4,
    parameter int                CHIME_ON  = 3,
    parameter int                CHIME_OFF = 5,
    parameter logic [N_WARN-1:0] PRI1_MASK = 8'b1110_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_WARN-1:0] fault_raw,
    input  logic              key,
    input  logic              brk,
    input  logic              park,
    input  logic              srv,
    input  logic              ack,
    output logic [N_WARN-1:0] warn,
    output logic              warn_pri1,
    output logic              warn_pri2,
    output logic              chime,
    output logic              start_permit
);

    localparam int DEB_W  = $clog2(DEB_CYC + 1);
    localparam int CNT_W  = $clog2(CHIME_ON + CHIME_OFF);

    // Last count value before the debounced level flips; reaching DEB_CYC
    // happens on the same edge that updates warn.
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHIME_ON + CHIME_OFF - 1);
    localparam logic [CNT_W-1:0] CNT_ON   = CNT_W'(CHIME_ON);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_CHECK   = 2'd1,
        ST_READY   = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    logic [N_WARN-1:0] warn_r;
    logic [N_WARN-1:0] warn_nxt_s;
    logic [DEB_W-1:0]  deb_r     [N_WARN];
    logic [DEB_W-1:0]  deb_nxt_s [N_WARN];
    logic [N_WARN-1:0] ack_mask_r;
    logic [N_WARN-1:0] ack_mask_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    state_t            state_r;
    state_t            state_nxt_s;
    logic              pri1_s;
    logic              pri2_pending_s;
    logic              req_s;

    // Priority classification and chime request from the registered warnings.
    always_comb begin
        pri1_s         = |(warn_r & PRI1_MASK);
        pri2_pending_s = |(warn_r & ~PRI1_MASK & ~ack_mask_r);
        req_s          = key & (pri1_s | (~srv & pri2_pending_s));
    end

    // Per-channel debounce: count consecutive disagreeing samples.
    always_comb begin
        warn_nxt_s = warn_r;
        for (int i = 0; i < N_WARN; i++) begin
            deb_nxt_s[i] = '0;
            if (fault_raw[i] != warn_r[i]) begin
                if (deb_r[i] == DEB_LAST) begin
                    warn_nxt_s[i] = fault_raw[i];
                    deb_nxt_s[i]  = '0;
                end else begin
                    deb_nxt_s[i] = deb_r[i] + DEB_W'(1);
                end
            end else begin
                deb_nxt_s[i] = '0;
            end
        end
    end

    // Acknowledge mask: only priority-2 bits, using the pre-edge warn value so
    // an ack coinciding with a newly rising warning does not mask it; a bit
    // drops as soon as its warning is inactive so a recurrence chimes again.
    always_comb begin
        ack_mask_nxt_s = ack_mask_r;
        if (ack) begin
            ack_mask_nxt_s = ack_mask_r | (warn_r & ~PRI1_MASK);
        end else begin
            ack_mask_nxt_s = ack_mask_r;
        end
        ack_mask_nxt_s = ack_mask_nxt_s & warn_r & ~PRI1_MASK;
    end

    // Cadence counter: parked at 0 while idle so each burst starts in ON phase.
    always_comb begin
        cnt_nxt_s = '0;
        if (!req_s) begin
            cnt_nxt_s = '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Start-interlock next-state logic; key removal overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        if (!key) begin
            state_nxt_s = ST_OFF;
        end else begin
            case (state_r)
                ST_OFF: begin
                    state_nxt_s = ST_CHECK;
                end
                ST_CHECK: begin
                    if (pri1_s && !srv) begin
                        state_nxt_s = ST_LOCKOUT;
                    end else if (brk && park) begin
                        state_nxt_s = ST_READY;
                    end else begin
                        state_nxt_s = ST_CHECK;
                    end
                end
                ST_READY: begin
                    if (pri1_s && !srv) begin
                        state_nxt_s = ST_LOCKOUT;
                    end else if (!(brk && park)) begin
                        state_nxt_s = ST_CHECK;
                    end else begin
                        state_nxt_s = ST_READY;
                    end
                end
                ST_LOCKOUT: begin
                    state_nxt_s = ST_LOCKOUT;
                end
                default: begin
                    state_nxt_s = ST_OFF;
                end
            endcase
        end
    end

    // State, debounce, acknowledge and cadence registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warn_r     <= '0;
            ack_mask_r <= '0;
            cnt_r      <= '0;
            state_r    <= ST_OFF;
            for (int i = 0; i < N_WARN; i++) begin
                deb_r[i] <= '0;
            end
        end else begin
            warn_r     <= warn_nxt_s;
            ack_mask_r <= ack_mask_nxt_s;
            cnt_r      <= cnt_nxt_s;
            state_r    <= state_nxt_s;
            for (int i = 0; i < N_WARN; i++) begin
                deb_r[i] <= deb_nxt_s[i];
            end
        end
    end

    assign warn         = warn_r;
    assign warn_pri1    = pri1_s;
    assign warn_pri2    = |(warn_r & ~PRI1_MASK);
    assign chime        = req_s & (cnt_r < CNT_ON);
    assign start_permit = (state_r == ST_READY);

endmodule

// File: tb/tb_warning_controller.sv
// Testbench for warning_controller: directed scenarios with fixed expectations
// plus a randomized run checked against a cycle-level behavioural model.
module tb_warning_controller;

    localparam int N_WARN    = 8;
    localparam int DEB_CYC   = 4;
    localparam int CHIME_ON  = 3;
    localparam int CHIME_OFF = 5;
    localparam int PERIOD    = CHIME_ON + CHIME_OFF;
    localparam int M_OFF = 0, M_CHECK = 1, M_READY = 2, M_LOCK = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N_WARN-1:0] fault_raw = '0;
    logic              key = 1'b0, brk = 1'b0, park = 1'b0, srv = 1'b0, ack = 1'b0;
    logic [N_WARN-1:0] warn;
    logic              warn_pri1, warn_pri2, chime, start_permit;
    logic [N_WARN-1:0] p1_mask = 8'b1110_0000;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_warn [N_WARN];
    int m_run  [N_WARN];
    int m_ack  [N_WARN];
    int m_cad;
    int m_state;

    warning_controller #(
        .N_WARN(N_WARN), .DEB_CYC(DEB_CYC), .CHIME_ON(CHIME_ON),
        .CHIME_OFF(CHIME_OFF), .PRI1_MASK(8'b1110_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fault_raw(fault_raw), .key(key), .brk(brk),
        .park(park), .srv(srv), .ack(ack), .warn(warn), .warn_pri1(warn_pri1),
        .warn_pri2(warn_pri2), .chime(chime), .start_permit(start_permit)
    );

    always #5 clk = ~clk;

    function automatic logic [N_WARN-1:0] m_warn_vec();
        logic [N_WARN-1:0] v = '0;
        for (int i = 0; i < N_WARN; i++) v[i] = (m_warn[i] != 0);
        return v;
    endfunction

    function automatic bit m_pri1();
        for (int i = 0; i < N_WARN; i++) if (p1_mask[i] && m_warn[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_pri2();
        for (int i = 0; i < N_WARN; i++) if (!p1_mask[i] && m_warn[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_req();
        if (!key) return 1'b0;
        if (m_pri1()) return 1'b1;
        if (srv) return 1'b0;
        for (int i = 0; i < N_WARN; i++)
            if (!p1_mask[i] && m_warn[i] != 0 && m_ack[i] == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_WARN; i++) begin
            m_warn[i] = 0; m_run[i] = 0; m_ack[i] = 0;
        end
        m_cad = 0;
        m_state = M_OFF;
    endtask

    // Advance the model by one clock edge using pre-edge model state and inputs.
    task automatic model_step();
        bit req_pre = m_req();
        bit p1_pre  = m_pri1();
        int nstate;
        for (int i = 0; i < N_WARN; i++) begin
            if (!p1_mask[i]) begin
                if (m_warn[i] == 0) m_ack[i] = 0;
                else if (ack) m_ack[i] = 1;
            end
        end
        m_cad = req_pre ? (m_cad + 1) % PERIOD : 0;
        if (!key) nstate = M_OFF;
        else begin
            case (m_state)
                M_OFF:   nstate = M_CHECK;
                M_CHECK: nstate = (p1_pre && !srv) ? M_LOCK : ((brk && park) ? M_READY : M_CHECK);
                M_READY: nstate = (p1_pre && !srv) ? M_LOCK : ((brk && park) ? M_READY : M_CHECK);
                default: nstate = M_LOCK;
            endcase
        end
        m_state = nstate;
        for (int i = 0; i < N_WARN; i++) begin
            if (int'(fault_raw[i]) != m_warn[i]) begin
                m_run[i]++;
                if (m_run[i] >= DEB_CYC) begin
                    m_warn[i] = int'(fault_raw[i]);
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    // One clock edge; returns 1 time unit after the edge so outputs are settled.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        fault_raw = '0; key = 1'b0; brk = 1'b0; park = 1'b0; srv = 1'b0; ack = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        @(posedge clk);
        #1;
        n_tests++; if (warn !== 8'h00) begin n_fail++; $display("FAIL reset_warn: got %h expected 00", warn); end
        n_tests++; if (warn_pri1 !== 1'b0 || warn_pri2 !== 1'b0) begin n_fail++; $display("FAIL reset_pri: got %b%b expected 00", warn_pri1, warn_pri2); end
        n_tests++; if (chime !== 1'b0) begin n_fail++; $display("FAIL reset_chime: got %b expected 0", chime); end
        n_tests++; if (start_permit !== 1'b0) begin n_fail++; $display("FAIL reset_permit: got %b expected 0", start_permit); end
        rst_n = 1'b1;
        tick();
        n_tests++; if (warn !== 8'h00 || chime !== 1'b0 || start_permit !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: warn=%h chime=%b permit=%b expected 00/0/0", warn, chime, start_permit); end
    endtask

    task automatic test_key_cycle();
        do_reset();
        brk = 1'b1; park = 1'b1; key = 1'b1;
        tick();
        n_tests++; if (start_permit !== 1'b0) begin n_fail++; $display("FAIL key_check: permit=%b expected 0", start_permit); end
        tick();
        n_tests++; if (start_permit !== 1'b1) begin n_fail++; $display("FAIL key_ready: permit=%b expected 1", start_permit); end
        key = 1'b0;
        tick();
        n_tests++; if (start_permit !== 1'b0) begin n_fail++; $display("FAIL key_off: permit=%b expected 0", start_permit); end
    endtask

    task automatic test_debounce_glitch();
        do_reset();
        fault_raw[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++; if (warn[0] !== 1'b0) begin n_fail++; $display("FAIL glitch_hi%0d: warn0=%b expected 0", c, warn[0]); end
        end
        fault_raw[0] = 1'b0;
        tick();
        n_tests++; if (warn[0] !== 1'b0) begin n_fail++; $display("FAIL glitch_end: warn0=%b expected 0", warn[0]); end
        fault_raw[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_tests++; if (warn[0] !== (c == 3)) begin n_fail++; $display("FAIL deb_rise%0d: warn0=%b expected %0d", c, warn[0], (c == 3)); end
        end
        n_tests++; if (warn_pri2 !== 1'b1 || warn_pri1 !== 1'b0) begin
            n_fail++; $display("FAIL deb_class: pri1=%b pri2=%b expected 0 1", warn_pri1, warn_pri2); end
        fault_raw[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_tests++; if (warn[0] !== (c != 3)) begin n_fail++; $display("FAIL deb_fall%0d: warn0=%b expected %0d", c, warn[0], (c != 3)); end
        end
    endtask

    task automatic test_lockout();
        do_reset();
        brk = 1'b1; park = 1'b1; key = 1'b1;
        tick(); tick();
        n_tests++; if (start_permit !== 1'b1) begin n_fail++; $display("FAIL lock_pre_ready: permit=%b expected 1", start_permit); end
        fault_raw[6] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_tests++; if (start_permit !== (c < 5)) begin n_fail++; $display("FAIL lock_edge%0d: permit=%b expected %0d", c, start_permit, (c < 5)); end
            if (c == 4) begin
                n_tests++; if (warn_pri1 !== 1'b1) begin n_fail++; $display("FAIL lock_pri1: pri1=%b expected 1", warn_pri1); end
            end
        end
        fault_raw[6] = 1'b0;
        repeat (6) tick();
        n_tests++; if (warn !== 8'h00 || start_permit !== 1'b0) begin
            n_fail++; $display("FAIL lock_hold: warn=%h permit=%b expected 00 0", warn, start_permit); end
        key = 1'b0;
        tick();
        key = 1'b1;
        tick();
        n_tests++; if (start_permit !== 1'b0) begin n_fail++; $display("FAIL lock_rekey_check: permit=%b expected 0", start_permit); end
        tick();
        n_tests++; if (start_permit !== 1'b1) begin n_fail++; $display("FAIL lock_rekey_ready: permit=%b expected 1", start_permit); end
    endtask

    task automatic test_service_bypass();
        do_reset();
        srv = 1'b1; fault_raw[7] = 1'b1; brk = 1'b1; park = 1'b1; key = 1'b1;
        tick(); tick();
        n_tests++; if (start_permit !== 1'b1) begin n_fail++; $display("FAIL srv_ready: permit=%b expected 1", start_permit); end
        tick(); tick();
        n_tests++; if (warn_pri1 !== 1'b1) begin n_fail++; $display("FAIL srv_pri1: pri1=%b expected 1", warn_pri1); end
        for (int j = 0; j < 16; j++) begin
            if (j > 0) tick();
            n_tests++; if (chime !== ((j % PERIOD) < CHIME_ON)) begin
                n_fail++; $display("FAIL srv_cadence%0d: chime=%b expected %0d", j, chime, ((j % PERIOD) < CHIME_ON)); end
        end
        n_tests++; if (start_permit !== 1'b1) begin n_fail++; $display("FAIL srv_keep_ready: permit=%b expected 1", start_permit); end
    endtask

    task automatic test_acknowledge();
        do_reset();
        brk = 1'b1; park = 1'b1; key = 1'b1; fault_raw[1] = 1'b1;
        repeat (4) tick();
        n_tests++; if (warn[1] !== 1'b1 || warn_pri2 !== 1'b1) begin
            n_fail++; $display("FAIL ack_warn1: warn1=%b pri2=%b expected 1 1", warn[1], warn_pri2); end
        for (int j = 0; j < PERIOD; j++) begin
            if (j > 0) tick();
            n_tests++; if (chime !== (j < CHIME_ON)) begin n_fail++; $display("FAIL ack_cadence%0d: chime=%b expected %0d", j, chime, (j < CHIME_ON)); end
        end
        ack = 1'b1; tick(); ack = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) tick();
            n_tests++; if (chime !== 1'b0) begin n_fail++; $display("FAIL ack_silenced%0d: chime=%b expected 0", j, chime); end
        end
        fault_raw[2] = 1'b1;
        repeat (3) tick();
        ack = 1'b1; tick(); ack = 1'b0;
        n_tests++; if (warn[2] !== 1'b1 || chime !== 1'b1) begin
            n_fail++; $display("FAIL ack_same_edge: warn2=%b chime=%b expected 1 1", warn[2], chime); end
        for (int j = 1; j < 4; j++) begin
            tick();
            n_tests++; if (chime !== (j < CHIME_ON)) begin n_fail++; $display("FAIL ack_restart%0d: chime=%b expected %0d", j, chime, (j < CHIME_ON)); end
        end
        ack = 1'b1; tick(); ack = 1'b0;
        n_tests++; if (chime !== 1'b0) begin n_fail++; $display("FAIL ack_both: chime=%b expected 0", chime); end
        fault_raw[1] = 1'b0;
        repeat (4) tick();
        n_tests++; if (warn[1] !== 1'b0) begin n_fail++; $display("FAIL ack_door_clear: warn1=%b expected 0", warn[1]); end
        fault_raw[1] = 1'b1;
        repeat (4) tick();
        n_tests++; if (warn[1] !== 1'b1 || chime !== 1'b1) begin
            n_fail++; $display("FAIL ack_recur: warn1=%b chime=%b expected 1 1", warn[1], chime); end
    endtask

    task automatic test_reset_mid_chime();
        n_tests++; if (chime !== 1'b1 || start_permit !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: chime=%b permit=%b expected 1 1", chime, start_permit); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++; if (chime !== 1'b0 || warn !== 8'h00 || start_permit !== 1'b0) begin
            n_fail++; $display("FAIL midrst: chime=%b warn=%h permit=%b expected 0 00 0", chime, warn, start_permit); end
        fault_raw = '0; key = 1'b0; brk = 1'b0; park = 1'b0; srv = 1'b0; ack = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        key = 1'b1; brk = 1'b1; park = 1'b1;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N_WARN; i++)
                if ($urandom_range(0, 11) == 0) fault_raw[i] = ~fault_raw[i];
            if ($urandom_range(0, 29) == 0) key = ~key;
            if ($urandom_range(0, 9) == 0) brk = ~brk;
            if ($urandom_range(0, 9) == 0) park = ~park;
            if ($urandom_range(0, 14) == 0) srv = ~srv;
            ack = ($urandom_range(0, 7) == 0);
            tick();
            n_tests++; if (warn !== m_warn_vec()) begin n_fail++; $display("FAIL rnd_warn c%0d: got %h expected %h", c, warn, m_warn_vec()); end
            n_tests++; if (warn_pri1 !== m_pri1()) begin n_fail++; $display("FAIL rnd_pri1 c%0d: got %b expected %b", c, warn_pri1, m_pri1()); end
            n_tests++; if (warn_pri2 !== m_pri2()) begin n_fail++; $display("FAIL rnd_pri2 c%0d: got %b expected %b", c, warn_pri2, m_pri2()); end
            n_tests++; if (chime !== (m_req() && m_cad < CHIME_ON)) begin
                n_fail++; $display("FAIL rnd_chime c%0d: got %b expected %b", c, chime, (m_req() && m_cad < CHIME_ON)); end
            n_tests++; if (start_permit !== (m_state == M_READY)) begin
                n_fail++; $display("FAIL rnd_permit c%0d: got %b expected %b", c, start_permit, (m_state == M_READY)); end
        end
    endtask

    initial begin
        test_reset();
        test_key_cycle();
        test_debounce_glitch();
        test_lockout();
        test_service_bypass();
        test_acknowledge();
        test_reset_mid_chime();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/warning_controller.md
# warning_controller

Clocked, parametrised successor to the combinational vehicle warning logic. It debounces N fault channels and splits them into priority-1 (start-inhibiting) and priority-2 (advisory) classes. A start-interlock FSM latches a lockout that can only be cleared by a key cycle, and a chime cadence generator lets the driver acknowledge priority-2 warnings per channel. It sits between the raw sensor inputs and the cluster/starter drivers.

## Interface
- N_WARN, 8, number of fault channels
- DEB_CYC, 4, consecutive disagreeing samples required to change a debounced warning (>=1)
- CHIME_ON, 3, chime high cycles per cadence period (>=1)
- CHIME_OFF, 5, chime low cycles per cadence period (>=1)
- PRI1_MASK, 8'b1110_0000, N_WARN-bit; 1 = channel is priority-1 (default: ch7 temp, ch6 airbag, ch5 battery)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fault_raw  in  N_WARN  raw fault conditions, 1 = fault present
- key  in  1  key present
- brk  in  1  brake pressed
- park  in  1  gear in park
- srv  in  1  service mode
- ack  in  1  driver acknowledge, sampled per cycle
- warn  out  N_WARN  debounced per-channel warnings
- warn_pri1  out  1  |(warn & PRI1_MASK)
- warn_pri2  out  1  |(warn & ~PRI1_MASK)
- chime  out  1  audible chime drive
- start_permit  out  1  starter enable

## Operation
- Debounce, per channel i: counter deb[i], width $clog2(DEB_CYC+1).
  - If fault_raw[i] != warn[i], deb[i] increments.
  - When deb[i] reaches DEB_CYC, warn[i] takes fault_raw[i] and deb[i] clears.
  - If fault_raw[i] == warn[i], deb[i] clears. Any single agreeing sample restarts the count.
- warn_pri1 and warn_pri2 are combinational from the warn register.
- ack_mask (N_WARN bits, priority-2 bits only):
  - ack=1 at an edge sets ack_mask |= warn & ~PRI1_MASK, using the pre-edge warn value.
  - A bit clears on the edge where its warn bit is 0, so a recurring fault chimes again.
- Chime request:
  - req = key & (warn_pri1 | (~srv & |(warn & ~PRI1_MASK & ~ack_mask))).
  - Priority-1 warnings cannot be acknowledged. srv suppresses priority-2 chime only.
- Cadence counter, width $clog2(CHIME_ON+CHIME_OFF):
  - Held at 0 while req=0.
  - While req=1 it counts modulo CHIME_ON+CHIME_OFF.
  - chime = req & (cnt < CHIME_ON). The first period therefore always starts in the ON phase.
- Interlock FSM states: OFF, CHECK, READY, LOCKOUT. key=0 forces OFF on the next edge from any state; this has highest priority.
  - OFF: key=1 -> CHECK.
  - CHECK: warn_pri1 & ~srv -> LOCKOUT; else brk & park -> READY; else stay.
  - READY: warn_pri1 & ~srv -> LOCKOUT; else ~(brk & park) -> CHECK.
  - LOCKOUT: stay until key=0. A fault clearing does not exit LOCKOUT.
- start_permit = (state == READY), decoded from the state register.

## Timing
- Reset (asynchronous, rst_n=0) clears warn, deb, ack_mask, the cadence counter and sets state=OFF. All outputs read 0 during and after reset until inputs act.
- Debounce latency: fault_raw asserted before edge 1 and held gives warn high after edge DEB_CYC. Release takes the same latency.
- key rises before edge k with brk=park=1 and no priority-1 fault: CHECK after edge k, READY (start_permit=1) after edge k+1.
- Priority-1 raw fault while in READY: warn after DEB_CYC edges, LOCKOUT on the following edge, start_permit=0 DEB_CYC+1 edges after onset.
- chime follows req combinationally through the counter register. The first high cycle coincides with req rising.
- ack asserted on the same edge a new priority-2 warn rises does not mask that channel.
- Mid-operation reset returns to OFF immediately and discards any latched lockout.

## Test plan
- Key cycle: brk=park=1, no faults, key 0->1 -> start_permit=0 after 1 edge, =1 after 2 edges; key=0 -> start_permit=0 next edge.
- Debounce glitch: fault_raw[0] high for 3 cycles, then low -> warn[0] stays 0. Held 4 cycles -> warn[0]=1 on the 4th edge, warn_pri2=1.
- Lockout: READY, fault_raw[6] (airbag) held -> start_permit=0 5 edges later. Clear the fault -> still LOCKOUT. key 0->1 -> READY after 2 edges.
- Service bypass: srv=1, fault_raw[7] held, key on -> READY, warn_pri1=1, chime cadence 3 high / 5 low repeating.
- Acknowledge: fault_raw[1] (door) held, key=1 -> chime 3-high/5-low. ack pulse -> chime 0. fault_raw[2] rises -> chime restarts with the ON phase. door clear then set again -> chime again.
- Reset mid-chime: rst_n=0 during chime=1 -> chime, warn, start_permit all 0 immediately.
